vscale_fetch_queue: RTL and testbench

Parametrised IF->DX instruction buffer: the next generation of the single inst_DX/PC_DX pipeline register, generalised to DEPTH entries.
- Decouples imem response timing (imem_wait) from decode stalls (stall_DX).
- Preserves NOP-on-kill semantics and carries the fetch-fault flag with each instruction.
- Sits between the imem port and the decode/execute stage of the core.

---
 rtl/vscale_fetch_queue.sv | 142 ++++++++++++++
 tb/tb_vscale_fetch_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vscale_fetch_queue.sv
// vscale_fetch_queue
//   IF->DX instruction buffer. It replaces the single inst_DX/PC_DX pipeline
//   register with a DEPTH-entry circular queue. The queue decouples imem
//   response timing from decode stalls. Each entry holds {PC, inst, badmem}.
//   When the queue is empty it presents a NOP, so a flushed or starved decode
//   stage executes harmless bubbles.
//
//   Optional build macro: VSCALE_FETCH_QUEUE_BYPASS_EN
//     When it is defined, an enqueue into an empty queue is shown on deq_*
//     in the same cycle. If decode also accepts it, the entry is never
//     written into storage.
//
//   Ports
//     clk         rising-edge clock
//     reset       asynchronous, active-high; clears count and pointers
//     kill        flush all entries and any same-cycle enqueue/dequeue
//     enq_valid   fetch response valid
//     enq_ready   queue can accept an entry (count != DEPTH)
//     enq_PC      PC of fetched word
//     enq_inst    fetched instruction word
//     enq_badmem  fetch fault for this word
//     deq_valid   head entry valid
//     deq_ready   decode consumes the head
//     deq_PC      head PC (holds last head value when empty)
//     deq_inst    head instruction, NOP_INST when not valid
//     deq_badmem  head fault flag, 0 when not valid
//     count       number of valid entries
module vscale_fetch_queue #(
  parameter int                    XPR_LEN    = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       kill,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [XPR_LEN-1:0]         enq_PC,
  input  logic [INST_WIDTH-1:0]      enq_inst,
  input  logic                       enq_badmem,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [XPR_LEN-1:0]         deq_PC,
  output logic [INST_WIDTH-1:0]      deq_inst,
  output logic                       deq_badmem,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage is data only; it is deliberately left out of reset.
  logic [XPR_LEN-1:0]    r_pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];
  logic                  r_bad_mem  [DEPTH];

  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [XPR_LEN-1:0]    r_pc_hold;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_bypass;
  logic                  w_bypass_take;
  logic                  w_enq_fire;
  logic                  w_deq_fire;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

`ifdef VSCALE_FETCH_QUEUE_BYPASS_EN
  // Empty queue with a live fetch: the fetched word goes straight to decode.
  assign w_bypass      = w_empty & enq_valid & ~kill;
  assign w_bypass_take = w_bypass & deq_ready;
`else
  assign w_bypass      = 1'b0;
  assign w_bypass_take = 1'b0;
`endif

  // enq_ready depends on count alone. A dequeue in the same cycle does not
  // free a slot for the enqueue, so there is no full-queue pass-through.
  assign enq_ready  = ~w_full;
  assign deq_valid  = ~w_empty | w_bypass;
  assign w_enq_fire = enq_valid & enq_ready & ~kill & ~w_bypass_take;
  assign w_deq_fire = ~w_empty & deq_ready & ~kill;
  assign count      = r_count;

  // Head presentation
  always_comb begin
    deq_PC     = r_pc_hold;
    deq_inst   = NOP_INST;
    deq_badmem = 1'b0;
    if (!w_empty) begin
      deq_PC     = r_pc_mem[r_rd_ptr];
      deq_inst   = r_inst_mem[r_rd_ptr];
      deq_badmem = r_bad_mem[r_rd_ptr];
    end else if (w_bypass) begin
      deq_PC     = enq_PC;
      deq_inst   = enq_inst;
      deq_badmem = enq_badmem;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_pc_mem[r_wr_ptr]   <= enq_PC;
      r_inst_mem[r_wr_ptr] <= enq_inst;
      r_bad_mem[r_wr_ptr]  <= enq_badmem;
    end
  end

  // Control state: pointers and occupancy; kill overrides everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (kill) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq_fire) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_deq_fire) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_enq_fire, w_deq_fire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Remember the most recent head PC so deq_PC stays stable when empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_pc_hold <= '0;
    else if (deq_valid) r_pc_hold <= deq_PC;
  end

endmodule

// File: tb/tb_vscale_fetch_queue.sv
module tb_vscale_fetch_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        kill;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_PC;
  logic [31:0] enq_inst;
  logic        enq_badmem;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_PC;
  logic [31:0] deq_inst;
  logic        deq_badmem;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  vscale_fetch_queue #(
    .XPR_LEN(32), .INST_WIDTH(32), .DEPTH(4), .NOP_INST(32'h00000013)
  ) dut (
    .clk(clk), .reset(reset), .kill(kill),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_PC(enq_PC),
    .enq_inst(enq_inst), .enq_badmem(enq_badmem),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_PC(deq_PC),
    .deq_inst(deq_inst), .deq_badmem(deq_badmem), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [31:0] pc;
    logic        bm;
    logic        dr;
    logic        kl;
    logic        xdv;
    logic [31:0] xpc;
    logic        xbm;
    logic [2:0]  xcnt;
    logic        chkpc;
  } vec_t;

  vec_t vecs[$];

  // Instruction word tagged with the low PC bits so the word identifies its entry
  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return {pc[11:0], 20'h00093};
  endfunction

  task automatic add(input logic ev, input logic [31:0] pc, input logic bm,
                     input logic dr, input logic kl, input logic xdv,
                     input logic [31:0] xpc, input logic xbm,
                     input logic [2:0] xcnt, input logic chkpc);
    vec_t v;
    v.ev = ev; v.pc = pc; v.bm = bm; v.dr = dr; v.kl = kl;
    v.xdv = xdv; v.xpc = xpc; v.xbm = xbm; v.xcnt = xcnt; v.chkpc = chkpc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [31:0] pc, input logic bm,
                       input logic dr, input logic kl);
    enq_valid  = ev;
    enq_PC     = pc;
    enq_inst   = mk_inst(pc);
    enq_badmem = bm;
    deq_ready  = dr;
    kill       = kl;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    //   ev  pc            bm  dr  kl   xdv xpc           xbm xcnt chkpc
    // Three enqueues while decode is stalled, then drain in order
    add(1, 32'h200, 0, 0, 0,   1, 32'h200, 0, 3'd1, 1);
    add(1, 32'h204, 0, 0, 0,   1, 32'h200, 0, 3'd2, 1);
    add(1, 32'h208, 0, 0, 0,   1, 32'h200, 0, 3'd3, 1);
    add(0, 32'h0,   0, 1, 0,   1, 32'h204, 0, 3'd2, 1);
    add(0, 32'h0,   0, 1, 0,   1, 32'h208, 0, 3'd1, 1);
    add(0, 32'h0,   0, 1, 0,   0, 32'h208, 0, 3'd0, 1);
    add(0, 32'h0,   0, 1, 0,   0, 32'h208, 0, 3'd0, 1);  // dequeue on empty
    // Fill to full, then enqueue 0x300 while full
    add(1, 32'h210, 0, 0, 0,   1, 32'h210, 0, 3'd1, 1);
    add(1, 32'h214, 0, 0, 0,   1, 32'h210, 0, 3'd2, 1);
    add(1, 32'h218, 0, 0, 0,   1, 32'h210, 0, 3'd3, 1);
    add(1, 32'h21C, 0, 0, 0,   1, 32'h210, 0, 3'd4, 1);
    add(1, 32'h300, 0, 0, 0,   1, 32'h210, 0, 3'd4, 1);
    add(1, 32'h300, 0, 1, 0,   1, 32'h214, 0, 3'd3, 1);  // no pass-through
    // Continuous enqueue+dequeue across pointer wrap
    add(1, 32'h220, 0, 1, 0,   1, 32'h218, 0, 3'd3, 1);
    add(1, 32'h224, 0, 1, 0,   1, 32'h21C, 0, 3'd3, 1);
    add(1, 32'h228, 0, 1, 0,   1, 32'h220, 0, 3'd3, 1);
    add(1, 32'h22C, 0, 1, 0,   1, 32'h224, 0, 3'd3, 1);
    add(1, 32'h230, 0, 1, 0,   1, 32'h228, 0, 3'd3, 1);
    add(1, 32'h234, 0, 1, 0,   1, 32'h22C, 0, 3'd3, 1);
    add(0, 32'h0,   0, 1, 0,   1, 32'h230, 0, 3'd2, 1);
    add(0, 32'h0,   0, 1, 0,   1, 32'h234, 0, 3'd1, 1);
    add(0, 32'h0,   0, 1, 0,   0, 32'h234, 0, 3'd0, 1);
    // Kill with three entries held plus a same-cycle enqueue and dequeue
    add(1, 32'h240, 0, 0, 0,   1, 32'h240, 0, 3'd1, 1);
    add(1, 32'h244, 0, 0, 0,   1, 32'h240, 0, 3'd2, 1);
    add(1, 32'h248, 0, 0, 0,   1, 32'h240, 0, 3'd3, 1);
    add(1, 32'h24C, 0, 1, 1,   0, 32'h0,   0, 3'd0, 0);
    add(0, 32'h0,   0, 1, 0,   0, 32'h0,   0, 3'd0, 0);
    // Fetch-fault flag travels with its entry
    add(1, 32'h400, 1, 0, 0,   1, 32'h400, 1, 3'd1, 1);
    add(1, 32'h404, 0, 0, 0,   1, 32'h400, 1, 3'd2, 1);
    add(0, 32'h0,   0, 1, 0,   1, 32'h404, 0, 3'd1, 1);
    add(0, 32'h0,   0, 1, 0,   0, 32'h404, 0, 3'd0, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_deq_valid", 32'(deq_valid), 32'h0);
    chk("rst_deq_inst",  deq_inst,       NOP);
    chk("rst_count",     32'(count),     32'h0);
    chk("rst_enq_ready", 32'(enq_ready), 32'h1);
    chk("rst_deq_PC",    deq_PC,         32'h0);
    chk("rst_deq_badmem", 32'(deq_badmem), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_deq_valid", 32'(deq_valid), 32'h0);
    chk("idle_deq_inst",  deq_inst,       NOP);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].ev, vecs[i].pc, vecs[i].bm, vecs[i].dr, vecs[i].kl);
      @(posedge clk); #1;
      chk($sformatf("v%0d_count", i),     32'(count),      32'(vecs[i].xcnt));
      chk($sformatf("v%0d_deq_valid", i), 32'(deq_valid),  32'(vecs[i].xdv));
      chk($sformatf("v%0d_enq_ready", i), 32'(enq_ready),  32'(vecs[i].xcnt != 3'd4));
      chk($sformatf("v%0d_deq_inst", i),  deq_inst,
          vecs[i].xdv ? mk_inst(vecs[i].xpc) : NOP);
      chk($sformatf("v%0d_deq_badmem", i), 32'(deq_badmem), 32'(vecs[i].xbm));
      if (vecs[i].chkpc)
        chk($sformatf("v%0d_deq_PC", i), deq_PC, vecs[i].xpc);
    end

    // Asynchronous reset between edges with two entries held
    @(negedge clk);
    drive(1'b1, 32'h4A0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h4A4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("arst_pre_count", 32'(count), 32'h2);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_deq_valid", 32'(deq_valid), 32'h0);
    chk("arst_count",     32'(count),     32'h0);
    chk("arst_deq_inst",  deq_inst,       NOP);
    chk("arst_enq_ready", 32'(enq_ready), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    #1;
`ifdef VSCALE_FETCH_QUEUE_BYPASS_EN
    chk("byp_same_cycle_valid", 32'(deq_valid), 32'h1);
    chk("byp_same_cycle_PC",    deq_PC,         32'h500);
`else
    chk("nobyp_same_cycle_valid", 32'(deq_valid), 32'h0);
`endif
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("post_rst_deq_valid", 32'(deq_valid), 32'h1);
    chk("post_rst_deq_PC",    deq_PC,         32'h500);
    chk("post_rst_count",     32'(count),     32'h1);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("post_rst_drain_count", 32'(count), 32'h0);

`ifdef VSCALE_FETCH_QUEUE_BYPASS_EN
    // Bypass consumed directly: nothing is stored
    @(negedge clk);
    drive(1'b1, 32'h510, 1'b0, 1'b1, 1'b0);
    #1;
    chk("byp_take_valid", 32'(deq_valid), 32'h1);
    chk("byp_take_PC",    deq_PC,         32'h510);
    chk("byp_take_inst",  deq_inst,       mk_inst(32'h510));
    @(posedge clk); #1;
    chk("byp_take_count", 32'(count), 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("byp_take_after_valid", 32'(deq_valid), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
